// File: rtl/arith_pipe.sv
// Pipelined RV integer unit for OP, OP-IMM, LUI and AUIPC with valid/ready issue and writeback.
// Define ARITH_MUL_EN to add MUL/MULH/MULHSU/MULHU (OP, funct7=0000001).
module arith_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             arith_request_i,
  output logic             arith_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  rs1_value_i,
  input  logic [XLEN-1:0]  rs2_value_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             writeback_valid_o,
  input  logic             writeback_ready_i,
  output logic [XLEN-1:0]  writeback_value_o,
  output logic [TAG_W-1:0] writeback_tag_o,
  output logic             writeback_illegal_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
`ifdef ARITH_MUL_EN
  localparam logic [6:0] F7Mul  = 7'b0000001;
`endif

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] operand_b;
  logic [ShW-1:0]  shamt;
  logic            is_op;
  logic            alt;
  logic            shift_imm_ok;
  logic            unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign unused_inst = ^{inst_i[19:15], inst_i[11:7]};

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

  assign is_op     = (opcode == OpcOp);
  assign operand_b = is_op ? rs2_value_i : imm_i;
  assign shamt     = operand_b[ShW-1:0];

  // Bit 30 selects SUB/SRA; for OP-IMM it only means SRAI, ADDI keeps it as immediate.
  assign alt = inst_i[30] && (is_op || funct3 == 3'b101);

  // On RV64 bit 25 is part of the 6-bit shamt, on RV32 it must be zero.
  assign shift_imm_ok = (inst_i[31:26] == 6'b000000 || inst_i[31:26] == 6'b010000) &&
                        (XLEN == 64 || !inst_i[25]);

  logic [XLEN-1:0] sra_out;
  logic [XLEN-1:0] alu_out;

  assign sra_out = $signed(rs1_value_i) >>> shamt;

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000: begin
        if (alt) alu_out = rs1_value_i - operand_b;
        else     alu_out = rs1_value_i + operand_b;
      end
      3'b001: alu_out = rs1_value_i << shamt;
      3'b010: alu_out = XLEN'($signed(rs1_value_i) < $signed(operand_b));
      3'b011: alu_out = XLEN'(rs1_value_i < operand_b);
      3'b100: alu_out = rs1_value_i ^ operand_b;
      3'b101: begin
        if (alt) alu_out = sra_out;
        else     alu_out = rs1_value_i >> shamt;
      end
      3'b110: alu_out = rs1_value_i | operand_b;
      default: alu_out = rs1_value_i & operand_b;
    endcase
  end

`ifdef ARITH_MUL_EN
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_out;

  // Extending per signedness makes one 2*XLEN unsigned product exact for all four variants.
  assign mul_a = {{XLEN{rs1_value_i[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b010)}},
                  rs1_value_i};
  assign mul_b = {{XLEN{rs2_value_i[XLEN-1] && (funct3 == 3'b001)}}, rs2_value_i};
  assign mul_prod = mul_a * mul_b;
  assign mul_out  = (funct3 == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
`endif

  logic [XLEN-1:0] result;
  logic            illegal;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opcode)
      OpcLui:   result = imm_u;
      OpcAuipc: result = pc_i + imm_u;
      OpcOpImm: begin
        result = alu_out;
        if ((funct3 == 3'b001 && (!shift_imm_ok || inst_i[30])) ||
            (funct3 == 3'b101 && !shift_imm_ok)) begin
          illegal = 1'b1;
        end
      end
      OpcOp: begin
        if (funct7 == F7Base ||
            (funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          result = alu_out;
`ifdef ARITH_MUL_EN
        end else if (funct7 == F7Mul && !funct3[2]) begin
          result = mul_out;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) result = '0;
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] illegal_q;
  logic [XLEN-1:0]   value_q [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];

  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] in_valid;
  logic [STAGES-1:0] in_illegal;
  logic [XLEN-1:0]   in_value [STAGES];
  logic [TAG_W-1:0]  in_tag   [STAGES];
  logic              accept;

  // A stage can take new data if it is empty or anything downstream frees up this cycle.
  always_comb begin
    stage_ready = '0;
    stage_ready[STAGES-1] = !valid_q[STAGES-1] || writeback_ready_i;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      stage_ready[k] = !valid_q[k] || stage_ready[k+1];
    end
  end

  assign arith_ready_o = stage_ready[0];
  assign accept        = arith_request_i && stage_ready[0] && !flush_i;

  always_comb begin
    in_valid    = '0;
    in_illegal  = '0;
    in_valid[0]   = accept;
    in_illegal[0] = illegal;
    in_value[0]   = result;
    in_tag[0]     = tag_i;
    for (int k = 1; k < int'(STAGES); k++) begin
      in_valid[k]   = valid_q[k-1];
      in_illegal[k] = illegal_q[k-1];
      in_value[k]   = value_q[k-1];
      in_tag[k]     = tag_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q   <= '0;
      illegal_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        value_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (flush_i) begin
          valid_q[k] <= 1'b0;
        end else if (stage_ready[k]) begin
          valid_q[k] <= in_valid[k];
        end
        // Data only moves with a valid op so a stalled head stays stable.
        if (stage_ready[k] && in_valid[k]) begin
          value_q[k]   <= in_value[k];
          tag_q[k]     <= in_tag[k];
          illegal_q[k] <= in_illegal[k];
        end
      end
    end
  end

  assign writeback_valid_o   = valid_q[STAGES-1];
  assign writeback_value_o   = value_q[STAGES-1];
  assign writeback_tag_o     = tag_q[STAGES-1];
  assign writeback_illegal_o = illegal_q[STAGES-1];

endmodule

// File: tb/tb_arith_pipe.sv
// Bench for arith_pipe: directed spec vectors then random traffic against an in-order queue model.
module tb_arith_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned STAGES = 2;

  logic        clk = 1'b0;
  logic        reset, flush, req, ready;
  logic [31:0] pc, inst, rs1, rs2;
  logic [4:0]  tag;
  logic        wb_valid, wb_ready, wb_illegal;
  logic [31:0] wb_value;
  logic [4:0]  wb_tag;

  always #5 clk = ~clk;

  arith_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .flush_i            (flush),
    .arith_request_i    (req),
    .arith_ready_o      (ready),
    .pc_i               (pc),
    .inst_i             (inst),
    .rs1_value_i        (rs1),
    .rs2_value_i        (rs2),
    .tag_i              (tag),
    .writeback_valid_o  (wb_valid),
    .writeback_ready_i  (wb_ready),
    .writeback_value_o  (wb_value),
    .writeback_tag_o    (wb_tag),
    .writeback_illegal_o(wb_illegal)
  );

  typedef struct {
    logic [31:0] val;
    logic [4:0]  tag;
    bit          ill;
    int          cyc;
  } ent_t;

  ent_t        q[$];
  int          now = 0;
  int          last_leave = -100;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          lit_en = 1'b0;
  logic [31:0] lit_val = '0;
  bit          lit_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", name, got, exp);
  endtask

  // Reference: RV32I arithmetic from the ISA rules, plain integer math.
  function automatic void ref_exec(input logic [31:0] w, input logic [31:0] pcv,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] v, output bit ill);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] immi, immu, y;
    int          sh;
    bit          alt, ok;
    longint      sp;
    longint unsigned up;
    opc  = w[6:0];
    f3   = w[14:12];
    f7   = w[31:25];
    immi = {{20{w[31]}}, w[31:20]};
    immu = {w[31:12], 12'h000};
    v    = 32'h0;
    ill  = 1'b0;
    case (opc)
      7'h37: v = immu;
      7'h17: v = pcv + immu;
      7'h13, 7'h33: begin
        y   = (opc == 7'h33) ? b : immi;
        sh  = int'(y[4:0]);
        alt = (f7 == 7'h20);
        if (opc == 7'h33 && f7 == 7'h01) begin
`ifdef ARITH_MUL_EN
          ill = f3[2];
          case (f3)
            3'd0: v = a * b;
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); v = sp[63:32]; end
            3'd2: begin sp = longint'($signed(a)) * longint'(b); v = sp[63:32]; end
            default: begin up = {32'h0, a} * {32'h0, b}; v = up[63:32]; end
          endcase
`else
          ill = 1'b1;
`endif
        end else begin
          if (opc == 7'h13) ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                                 (f3 == 3'd5) ? (f7 == 7'h00 || alt) : 1'b1;
          else ok = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
          ill = !ok;
          case (f3)
            3'd0: v = (opc == 7'h33 && alt) ? a - b : a + y;
            3'd1: v = a << sh;
            3'd2: v = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: v = (a < y) ? 32'd1 : 32'd0;
            3'd4: v = a ^ y;
            3'd5: v = (a >> sh) | ((alt && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            3'd6: v = a | y;
            default: v = a & y;
          endcase
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) v = 32'h0;
  endfunction

  // One clock: check outputs against the queue model, then advance the model across the edge.
  task automatic tick();
    bit   exp_valid, exp_ready, acc, fire;
    int   vis;
    ent_t e;
    #1;
    exp_ready = (q.size() < STAGES) || wb_ready;
    exp_valid = 1'b0;
    if (q.size() > 0) begin
      vis = q[0].cyc + int'(STAGES);
      if (last_leave + 1 > vis) vis = last_leave + 1;
      exp_valid = (now >= vis);
    end
    chk("ready", 32'(ready), 32'(exp_ready));
    chk("valid", 32'(wb_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("value", wb_value, q[0].val);
      chk("tag", 32'(wb_tag), 32'(q[0].tag));
      chk("illegal", 32'(wb_illegal), 32'(q[0].ill));
    end
    acc  = req && exp_ready && !flush && !reset;
    fire = exp_valid && wb_ready;
    if (acc) begin
      e.tag = tag;
      e.cyc = now;
      if (lit_en) begin
        e.val = lit_val;
        e.ill = lit_ill;
      end else begin
        ref_exec(inst, pc, rs1, rs2, e.val, e.ill);
      end
    end
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
    end else begin
      if (fire) begin
        void'(q.pop_front());
        last_leave = now;
      end
      if (acc) q.push_back(e);
    end
    now++;
    @(negedge clk);
  endtask

  task automatic op(input logic [31:0] w, input logic [31:0] pcv, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] t, input bit use_lit,
                    input logic [31:0] lv, input bit li);
    req = 1'b1; inst = w; pc = pcv; rs1 = a; rs2 = b; tag = t;
    lit_en = use_lit; lit_val = lv; lit_ill = li;
    tick();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    lit_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(5))
      0: w[6:0] = 7'h13;
      1, 2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      default: ;
    endcase
    if ($urandom_range(3) != 0) begin
      case ($urandom_range(2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: w[31:25] = 7'h01;
      endcase
    end
    return w;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; req = 1'b0; inst = '0; pc = '0;
    rs1 = '0; rs2 = '0; tag = '0; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_value", wb_value, 32'd0);
    chk("rst_tag", 32'(wb_tag), 32'd0);
    chk("rst_illegal", 32'(wb_illegal), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic latency: addi x1,x3,5 with rs1=2.
    op(32'h0051_8093, 32'h0, 32'd2, 32'd0, 5'd3, 1'b1, 32'd7, 1'b0);
    idle(3);

    // Back-to-back: slli then sub.
    op(32'h0020_9113, 32'h0, 32'd5, 32'd0, 5'd4, 1'b1, 32'h14, 1'b0);
    op(32'h4020_8133, 32'h0, 32'h10, 32'd5, 5'd5, 1'b1, 32'hB, 1'b0);
    idle(3);

    // Backpressure: two ADDs fill the pipe, the third waits until ready returns.
    wb_ready = 1'b0;
    op(32'h0020_81B3, 32'h0, 32'd1, 32'd1, 5'd6, 1'b0, 32'h0, 1'b0);
    op(32'h0020_81B3, 32'h0, 32'd2, 32'd2, 5'd7, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) op(32'h0020_81B3, 32'h0, 32'd3, 32'd3, 5'd8, 1'b0, 32'h0, 1'b0);
    wb_ready = 1'b1;
    op(32'h0020_81B3, 32'h0, 32'd3, 32'd3, 5'd8, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Flush with a same-cycle request, then a fresh op at normal latency.
    op(32'h0051_8093, 32'h0, 32'd1, 32'd0, 5'd9, 1'b0, 32'h0, 1'b0);
    op(32'h0051_8093, 32'h0, 32'd2, 32'd0, 5'd10, 1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    op(32'h0051_8093, 32'h0, 32'd3, 32'd0, 5'd11, 1'b0, 32'h0, 1'b0);
    flush = 1'b0;
    idle(3);
    op(32'h0051_8093, 32'h0, 32'd4, 32'd0, 5'd12, 1'b1, 32'd9, 1'b0);
    idle(3);

    // Boundary encodings.
    op(32'h4020_D1B3, 32'h0, 32'h8000_0000, 32'd31, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b0);
    op(32'h0020_B1B3, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'd1, 1'b0);
    op(32'h0000_1097, 32'h100, 32'h0, 32'h0, 5'd15, 1'b1, 32'h1100, 1'b0);
    op(32'h0000_007F, 32'h0, 32'h1234, 32'h5678, 5'd16, 1'b1, 32'h0, 1'b1);
    op(32'hFFFF_F0B7, 32'h0, 32'h0, 32'h0, 5'd17, 1'b1, 32'hFFFF_F000, 1'b0);
    op(32'h4010_9093, 32'h0, 32'h1, 32'h0, 5'd18, 1'b1, 32'h0, 1'b1);
`ifdef ARITH_MUL_EN
    op(32'h0220_81B3, 32'h0, 32'd6, 32'd7, 5'd19, 1'b1, 32'd42, 1'b0);
    op(32'h0220_B1B3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 1'b1, 32'hFFFF_FFFE, 1'b0);
`else
    op(32'h0220_81B3, 32'h0, 32'd6, 32'd7, 5'd19, 1'b1, 32'h0, 1'b1);
    op(32'h0220_B1B3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 1'b1, 32'h0, 1'b1);
`endif
    idle(3);

    // Reset while a result is stalled on the output zeroes the output registers.
    wb_ready = 1'b0;
    op(32'h0051_8093, 32'h0, 32'h55, 32'h0, 5'd21, 1'b1, 32'h5A, 1'b0);
    idle(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_value", wb_value, 32'd0);
    chk("mid_rst_tag", 32'(wb_tag), 32'd0);
    chk("mid_rst_illegal", 32'(wb_illegal), 32'd0);
    wb_ready = 1'b1;
    idle(2);

    // Random traffic with backpressure, flushes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      req      = ($urandom_range(3) != 0);
      inst     = rand_inst();
      pc       = $urandom;
      rs1      = rand_operand();
      rs2      = rand_operand();
      tag      = 5'($urandom);
      wb_ready = ($urandom_range(9) < 7);
      flush    = ($urandom_range(49) == 0);
      reset    = ($urandom_range(199) == 0);
      lit_en   = 1'b0;
      tick();
    end
    flush = 1'b0;
    reset = 1'b0;
    wb_ready = 1'b1;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
